// File: rtl/atm_pin_sender.sv
// atm_pin_sender
// Customer-side driver for the ATM card/PIN protocol. On a legal start it
// inserts the card (cartao=1), sends value 0, then the three PIN digits, each
// held HOLD_CYCLES cycles. It then waits up to RESP_TIMEOUT cycles for
// cash_ok / card_destroyed, and reports done or fail.
//
// Optional feature macro: ATM_PIN_RETRY_EN
//   defined   : a response timeout re-inserts and resends the PIN, up to
//               MAX_TRIES attempts in total.
//   undefined : a single attempt; a timeout goes straight to FAIL.
//
// Ports:
//   clk_2          clock
//   rst            asynchronous active-high reset
//   start          request a transaction (sampled in IDLE/DONE/FAIL only)
//   pin[8:0]       digits: [8:6]=d1, [5:3]=d2, [2:0]=d3
//   cash_ok        ATM dispensing cash (level, only looked at in WAIT_RESP)
//   card_destroyed ATM destroyed the card (level, wins over cash_ok)
//   cartao         card-inserted line to the ATM
//   valor[2:0]     value/digit bus to the ATM
//   busy           high while a transaction is in flight
//   done / fail    terminal status levels
//   error          one-cycle pulse for a start carrying an illegal PIN
//   attempts[1:0]  attempts issued in the current transaction
module atm_pin_sender #(
    parameter int HOLD_CYCLES  = 2,
    parameter int RESP_TIMEOUT = 8,
    parameter int MAX_TRIES    = 3
) (
    input  logic       clk_2,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] pin,
    input  logic       cash_ok,
    input  logic       card_destroyed,
    output logic       cartao,
    output logic [2:0] valor,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic       error,
    output logic [1:0] attempts
);

    localparam int CNT_MAX = (HOLD_CYCLES > RESP_TIMEOUT) ? HOLD_CYCLES : RESP_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Elaboration-time parameter sanity checks.
    if (HOLD_CYCLES < 1 || RESP_TIMEOUT < 1) begin : g_bad_timing
        $error("atm_pin_sender: HOLD_CYCLES and RESP_TIMEOUT must be >= 1");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 3) begin : g_bad_tries
        $error("atm_pin_sender: MAX_TRIES must be in 1..3");
    end

`ifdef ATM_PIN_RETRY_EN
    localparam logic [1:0] EFF_TRIES = 2'(MAX_TRIES);
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INSERT    = 3'd1,
        S_SEND_D1   = 3'd2,
        S_SEND_D2   = 3'd3,
        S_SEND_D3   = 3'd4,
        S_WAIT_RESP = 3'd5,
        S_DONE      = 3'd6,
        S_FAIL      = 3'd7
    } state_t;

    // The ATM only registers a digit when the bus changes, so neighbours
    // must differ, and the first digit must differ from the value-0 symbol.
    function automatic logic pin_legal(input logic [8:0] p);
        return (p[8:6] != 3'd0) && (p[5:3] != p[8:6]) && (p[2:0] != p[5:3]);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       pin_q, pin_d;
    logic [1:0]       attempts_q, attempts_d;
    logic             cartao_q, cartao_d;
    logic [2:0]       valor_q, valor_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic             error_q, error_d;
    logic             hold_last_s, resp_last_s;

    assign hold_last_s = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
    assign resp_last_s = (cnt_q == CNT_W'(RESP_TIMEOUT - 1));

    // Next-state, latch and attempt bookkeeping.
    always_comb begin
        state_d    = state_q;
        pin_d      = pin_q;
        attempts_d = attempts_q;
        error_d    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    if (pin_legal(pin)) begin
                        state_d    = S_INSERT;
                        pin_d      = pin;
                        attempts_d = 2'd1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_INSERT: begin
                if (hold_last_s) state_d = S_SEND_D1;
                else             state_d = state_q;
            end
            S_SEND_D1: begin
                if (hold_last_s) state_d = S_SEND_D2;
                else             state_d = state_q;
            end
            S_SEND_D2: begin
                if (hold_last_s) state_d = S_SEND_D3;
                else             state_d = state_q;
            end
            S_SEND_D3: begin
                if (hold_last_s) state_d = S_WAIT_RESP;
                else             state_d = state_q;
            end
            S_WAIT_RESP: begin
                if (card_destroyed) begin
                    state_d = S_FAIL;
                end else if (cash_ok) begin
                    state_d = S_DONE;
                end else if (resp_last_s) begin
`ifdef ATM_PIN_RETRY_EN
                    // Retry re-enters INSERT with cartao still high; the value
                    // 0 symbol re-arms the ATM for a new PIN.
                    if (attempts_q < EFF_TRIES) begin
                        state_d    = S_INSERT;
                        attempts_d = attempts_q + 2'd1;
                    end else begin
                        state_d = S_FAIL;
                    end
`else
                    state_d = S_FAIL;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Hold/timeout counter: restarts on every state entry, idle when not timing.
    always_comb begin
        cnt_d = '0;
        case (state_q)
            S_INSERT, S_SEND_D1, S_SEND_D2, S_SEND_D3, S_WAIT_RESP: begin
                if (state_d != state_q) cnt_d = '0;
                else                    cnt_d = cnt_q + CNT_W'(1);
            end
            default: cnt_d = '0;
        endcase
    end

    // Output values for the upcoming state, so registered outputs line up with state_q.
    always_comb begin
        cartao_d = 1'b0;
        valor_d  = 3'd0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        fail_d   = 1'b0;
        case (state_d)
            S_INSERT: begin
                cartao_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_SEND_D1: begin
                cartao_d = 1'b1;
                busy_d   = 1'b1;
                valor_d  = pin_d[8:6];
            end
            S_SEND_D2: begin
                cartao_d = 1'b1;
                busy_d   = 1'b1;
                valor_d  = pin_d[5:3];
            end
            S_SEND_D3, S_WAIT_RESP: begin
                cartao_d = 1'b1;
                busy_d   = 1'b1;
                valor_d  = pin_d[2:0];
            end
            S_DONE:  done_d = 1'b1;
            S_FAIL:  fail_d = 1'b1;
            default: cartao_d = 1'b0;
        endcase
    end

    // State, counters, latched PIN and registered outputs.
    always_ff @(posedge clk_2 or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pin_q      <= 9'd0;
            attempts_q <= 2'd0;
            cartao_q   <= 1'b0;
            valor_q    <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pin_q      <= pin_d;
            attempts_q <= attempts_d;
            cartao_q   <= cartao_d;
            valor_q    <= valor_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            error_q    <= error_d;
        end
    end

    assign cartao   = cartao_q;
    assign valor    = valor_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fail     = fail_q;
    assign error    = error_q;
    assign attempts = attempts_q;

endmodule

// File: tb/tb_atm_pin_sender.sv
// Testbench for atm_pin_sender. The reference model describes each
// transaction as a sequence of protocol segments (value 0, d1, d2, d3, wait)
// per attempt and derives the expected output word for every cycle.
module tb_atm_pin_sender;

    localparam int H = 2;
    localparam int T = 8;
`ifdef ATM_PIN_RETRY_EN
    localparam int N = 3;
`else
    localparam int N = 1;
`endif
    localparam int L = 4 * H + T;

    logic       clk_2 = 1'b0;
    logic       rst;
    logic       start;
    logic [8:0] pin;
    logic       cash_ok;
    logic       card_destroyed;
    logic       cartao;
    logic [2:0] valor;
    logic       busy;
    logic       done;
    logic       fail;
    logic       error;
    logic [1:0] attempts;

    int checks = 0;
    int errors = 0;

    // Model of the status left behind by the previous transaction.
    logic       m_done;
    logic       m_fail;
    logic [1:0] m_att;

    atm_pin_sender #(.HOLD_CYCLES(H), .RESP_TIMEOUT(T), .MAX_TRIES(3)) dut (
        .clk_2(clk_2), .rst(rst), .start(start), .pin(pin),
        .cash_ok(cash_ok), .card_destroyed(card_destroyed),
        .cartao(cartao), .valor(valor), .busy(busy), .done(done),
        .fail(fail), .error(error), .attempts(attempts)
    );

    always #5 clk_2 = ~clk_2;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [9:0] pack(input logic c, input logic [2:0] v, input logic b,
                                        input logic d, input logic f, input logic e,
                                        input logic [1:0] a);
        return {c, v, b, d, f, e, a};
    endfunction

    function automatic logic [9:0] observed();
        return {cartao, valor, busy, done, fail, error, attempts};
    endfunction

    function automatic logic legal(input logic [8:0] p);
        return (p[8:6] != 3'd0) && (p[5:3] != p[8:6]) && (p[2:0] != p[5:3]);
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1; start = 1'b0; pin = 9'd0; cash_ok = 1'b0; card_destroyed = 1'b0;
        repeat (3) @(posedge clk_2);
        #1;
        check_val("reset", 32'(observed()), 32'(pack(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0)));
        rst = 1'b0;
        m_done = 1'b0; m_fail = 1'b0; m_att = 2'd0;
    endtask

    // kind: 0 no response, 1 cash_ok, 2 card_destroyed, 3 both together.
    task automatic run_txn(input logic [8:0] p, input int kind, input int att, input int dly);
        int e_idx;
        int a;
        int pos;
        logic [2:0] v;
        logic [9:0] exp_w;
        logic [1:0] fin_att;
        if (kind == 0) begin
            e_idx   = N * L;
            fin_att = 2'(N);
        end else begin
            e_idx   = (att - 1) * L + 4 * H + dly + 1;
            fin_att = 2'(att);
        end
        start = 1'b1; pin = p; cash_ok = 1'b0; card_destroyed = 1'b0;
        @(posedge clk_2);
        #1;
        start = 1'b0;
        for (int j = 0; j <= e_idx; j++) begin
            a   = j / L + 1;
            pos = j % L;
            cash_ok = 1'b0; card_destroyed = 1'b0; start = 1'b0;
            if (j < e_idx && pos >= 4 * H) begin
                if (kind != 0 && a == att && pos - 4 * H == dly) begin
                    cash_ok        = (kind == 1 || kind == 3);
                    card_destroyed = (kind >= 2);
                end
            end else if (j < e_idx) begin
                // Noise that must be ignored while sending.
                cash_ok        = 1'($urandom);
                card_destroyed = 1'($urandom);
                start          = 1'($urandom);
                pin            = 9'($urandom);
            end
            @(negedge clk_2);
            if (j < e_idx) begin
                if (pos < H)          v = 3'd0;
                else if (pos < 2 * H) v = p[8:6];
                else if (pos < 3 * H) v = p[5:3];
                else                  v = p[2:0];
                exp_w = pack(1'b1, v, 1'b1, 1'b0, 1'b0, 1'b0, 2'(a));
            end else begin
                exp_w = pack(1'b0, 3'd0, 1'b0, kind == 1, kind != 1, 1'b0, fin_att);
            end
            check_val($sformatf("txn_p%03h_c%0d", p, j), 32'(observed()), 32'(exp_w));
            @(posedge clk_2);
            #1;
        end
        cash_ok = 1'b0; card_destroyed = 1'b0; start = 1'b0;
        m_done = (kind == 1);
        m_fail = (kind != 1);
        m_att  = fin_att;
    endtask

    task automatic bad_start(input logic [8:0] p);
        start = 1'b1; pin = p;
        @(posedge clk_2);
        #1;
        start = 1'b0;
        @(negedge clk_2);
        check_val("err_pulse", 32'(observed()), 32'(pack(1'b0, 3'd0, 1'b0, m_done, m_fail, 1'b1, m_att)));
        @(posedge clk_2);
        #1;
        @(negedge clk_2);
        check_val("err_clear", 32'(observed()), 32'(pack(1'b0, 3'd0, 1'b0, m_done, m_fail, 1'b0, m_att)));
        @(posedge clk_2);
        #1;
    endtask

    task automatic reset_mid(input logic [8:0] p);
        start = 1'b1; pin = p;
        @(posedge clk_2);
        #1;
        start = 1'b0;
        repeat (2 * H) @(posedge clk_2);
        #1;
        check_val("pre_rst_d2", 32'(observed()), 32'(pack(1'b1, p[5:3], 1'b1, 1'b0, 1'b0, 1'b0, 2'd1)));
        #1;
        rst = 1'b1;
        #1;
        check_val("rst_async", 32'(observed()), 32'(pack(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0)));
        @(posedge clk_2);
        #1;
        rst = 1'b0;
        m_done = 1'b0; m_fail = 1'b0; m_att = 2'd0;
    endtask

    initial begin
        logic [8:0] rp;
        int kind;
        do_reset();
        run_txn({3'd1, 3'd3, 3'd7}, 1, 1, 1);
        bad_start({3'd1, 3'd1, 3'd7});
        bad_start({3'd0, 3'd3, 3'd7});
        run_txn({3'd2, 3'd4, 3'd6}, 0, 1, 0);
        run_txn({3'd5, 3'd2, 3'd5}, 3, N, int'($urandom_range(T - 1, 0)));
        reset_mid({3'd3, 3'd6, 3'd1});
        run_txn({3'd3, 3'd6, 3'd1}, 1, N, T - 1);
        for (int i = 0; i < 24; i++) begin
            rp = 9'($urandom);
            if (!legal(rp)) begin
                bad_start(rp);
            end else begin
                kind = int'($urandom_range(3, 0));
                run_txn(rp, kind, int'($urandom_range(N, 1)), int'($urandom_range(T - 1, 0)));
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/atm_pin_sender.md
Name: atm_pin_sender

Overview:
- Customer-side driver for the ATM card/PIN switch protocol; it is the other end of the ATM controller FSM.
- Takes a 3-digit PIN and produces the exact card/value sequence the ATM expects on the cartao/valor lines: card in, value 0, then digit1, digit2, digit3.
- Watches the ATM's cash / card-destroyed indications, retries wrong-PIN attempts and reports done/fail.
- Used in bench and board demos to drive the ATM without hand-toggling SWI.

Parameters:
- HOLD_CYCLES, 2, cycles each protocol symbol (value 0 or a digit) is held stable; must be >= 1.
- RESP_TIMEOUT, 8, cycles to wait in WAIT_RESP for cash_ok/card_destroyed before treating the attempt as rejected; must be >= 1.
- MAX_TRIES, 3, maximum PIN attempts per start; range 1..3.

Ports:
- clk_2  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a PIN transaction; sampled only in IDLE, DONE or FAIL
- pin  input  9  PIN digits: [8:6]=digit1, [5:3]=digit2, [2:0]=digit3
- cash_ok  input  1  ATM dispensing-cash indication (level)
- card_destroyed  input  1  ATM card-destroyed indication (level)
- cartao  output  1  card-inserted line to the ATM
- valor  output  3  value/digit bus to the ATM
- busy  output  1  high in every state except IDLE, DONE, FAIL
- done  output  1  level; high in DONE
- fail  output  1  level; high in FAIL
- error  output  1  one-cycle pulse when start carries an illegal PIN
- attempts  output  2  attempts issued in the current transaction

Behaviour:
- Reset, asynchronous and immediate, including mid-transaction:
  - state=IDLE; cartao=0, valor=0, busy=0, done=0, fail=0, error=0, attempts=0.
  - Hold counter, timeout counter and latched PIN are cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- PIN legality, checked on the start cycle:
  - d1!=0, d2!=d1, d3!=d2.
  - The ATM only accepts a digit when the bus changes, so equal neighbours cannot be sent.
  - Illegal PIN: error=1 for exactly one cycle, state unchanged, nothing latched.
- Legal start in IDLE/DONE/FAIL: latch pin, attempts<=1, clear done/fail, go to INSERT next cycle. start while busy is ignored.
- States:
  - IDLE: cartao=0, valor=0.
  - INSERT: cartao=1, valor=0 for HOLD_CYCLES cycles -> SEND_D1.
  - SEND_D1 / SEND_D2 / SEND_D3: cartao=1, valor=d1/d2/d3, each held HOLD_CYCLES cycles. Order is SEND_D1 -> SEND_D2 -> SEND_D3 -> WAIT_RESP.
  - WAIT_RESP: cartao=1, valor=d3 held; timeout counter runs from 0.
    - card_destroyed=1 -> FAIL. card_destroyed has priority if both indications are high in the same cycle.
    - else cash_ok=1 -> DONE.
    - else counter reaches RESP_TIMEOUT: the attempt was rejected.
      - attempts<MAX_TRIES: attempts+=1 -> INSERT. cartao stays 1; value 0 re-arms the ATM.
      - else -> FAIL.
  - DONE: cartao=0, valor=0, done=1 until the next legal start or reset.
  - FAIL: cartao=0, valor=0, fail=1 until the next legal start or reset.
- cash_ok/card_destroyed are ignored outside WAIT_RESP.
- Hold and timeout counters reset to 0 on every state entry.
- A full attempt with no response takes exactly 4*HOLD_CYCLES+RESP_TIMEOUT cycles from INSERT entry to the retry decision.
- attempts saturates at MAX_TRIES and never wraps.

Optional Feature:
- Macro: ATM_PIN_RETRY_EN.
- Defined: retry on timeout as above, up to MAX_TRIES attempts.
- Undefined: MAX_TRIES is treated as 1. A WAIT_RESP timeout goes directly to FAIL with attempts=1, and the retry path is not built.

Test Plan:
1. Reset, then start with pin=1,3,7 and HOLD_CYCLES=2; cash_ok rises 1 cycle after WAIT_RESP entry -> valor trace 0,0,1,1,3,3,7,7 with cartao=1, then done=1, attempts=1, cartao=0.
2. Start with pin=1,1,7 -> error pulses exactly 1 cycle, busy stays 0, cartao stays 0; pin=0,3,7 gives the same.
3. Start with pin=2,4,6 and no responses (retry enabled) -> 3 full sequences, attempts 1 -> 2 -> 3, then fail=1 after 3*(8+8)=48 cycles.
4. In WAIT_RESP, card_destroyed and cash_ok both asserted in the same cycle -> FAIL, done=0.
5. Assert rst during SEND_D2 -> all outputs 0 in the same cycle; a following legal start restarts from INSERT with attempts=1.
6. Build without ATM_PIN_RETRY_EN, no responses -> fail=1 after a single attempt, attempts=1.
